// File: rtl/i2c_slave_regs.sv
// ============================================================================
// Module   : i2c_slave_regs
// Purpose  : I2C target with an internal byte-wide register file. Acknowledges
//            DEV_ADDR, supports register-pointer write, burst write and burst
//            read (current pointer or after repeated START) with
//            auto-increment. SCL/SDA are oversampled on ck; no clock
//            stretching.
// Ports    : ck        - system clock, at least 16x SCL
//            arst_n    - asynchronous active-low reset (synchronous release)
//            scl       - raw I2C clock from the bus
//            sdai      - raw I2C data from the bus
//            sdao      - open-drain data drive (0 = pull low, 1 = release)
//            lcl_addr  - local read index
//            lcl_rdata - regs[lcl_addr], combinational
//            wr_strb   - one-ck pulse when an I2C write commits a register
//            wr_idx    - index written, valid with wr_strb
//            busy      - high from START until STOP
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         NUM_REGS = 16,
    parameter int         AW       = $clog2(NUM_REGS)
) (
    input  logic          ck,
    input  logic          arst_n,
    input  logic          scl,
    input  logic          sdai,
    output logic          sdao,
    input  logic [AW-1:0] lcl_addr,
    output logic [7:0]    lcl_rdata,
    output logic          wr_strb,
    output logic [AW-1:0] wr_idx,
    output logic          busy
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV_ADDR = 4'd1,
        ST_DEV_ACK  = 4'd2,
        ST_REG_ADDR = 4'd3,
        ST_REG_ACK  = 4'd4,
        ST_WR_DATA  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_DATA  = 4'd7,
        ST_RD_ACK   = 4'd8
    } state_t;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a ck edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Input conditioning: [0],[1] synchronize, [2] holds the previous
    // synchronized value for edge detection. Reset to the idle bus level
    // so no spurious edge is seen after reset.
    // ------------------------------------------------------------------
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sdai};
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = scl_q[1] & ~scl_q[2];
    assign w_scl_fall = ~scl_q[1] & scl_q[2];
    assign w_start    = ~sda_q[1] & sda_q[2] & scl_q[1];
    assign w_stop     = sda_q[1] & ~sda_q[2] & scl_q[1];

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t        state_q;
    logic [2:0]    cnt_q;
    logic [7:0]    sr_q;
    logic [AW-1:0] ptr_q;
    logic          rw_q;
    logic          mack_q;      // master ACK seen in RD_ACK, waiting for fall
    logic          sdao_q;
    logic          wr_strb_q;
    logic [AW-1:0] wr_idx_q;
    logic          busy_q;
    logic [7:0]    regs_q [NUM_REGS];

    logic [7:0]    w_byte;
    logic          w_last;
    logic [2:0]    w_cnt_m1;
    logic [AW-1:0] w_ptr_inc;
    logic [7:0]    w_cur;

    // Byte as it will look once the bit being sampled now is shifted in.
    assign w_byte    = {sr_q[6:0], sda_q[1]};
    assign w_last    = (cnt_q == 3'd0);
    assign w_cnt_m1  = cnt_q - 3'd1;
    assign w_ptr_inc = ptr_q + AW'(1);
    assign w_cur     = regs_q[ptr_q];

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd7;
            sr_q      <= 8'h00;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            mack_q    <= 1'b0;
            sdao_q    <= 1'b1;
            wr_strb_q <= 1'b0;
            wr_idx_q  <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wr_strb_q <= 1'b0;

            if (w_stop) begin
                state_q <= ST_IDLE;
                sdao_q  <= 1'b1;
                busy_q  <= 1'b0;
                mack_q  <= 1'b0;
            end else if (w_start) begin
                state_q <= ST_DEV_ADDR;
                cnt_q   <= 3'd7;
                sdao_q  <= 1'b1;
                busy_q  <= 1'b1;
                mack_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        sdao_q <= 1'b1;
                    end

                    ST_DEV_ADDR: begin
                        if (w_scl_rise) begin
                            sr_q <= w_byte;
                            if (w_last) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    rw_q    <= w_byte[0];
                                    state_q <= ST_DEV_ACK;
                                end else begin
                                    state_q <= ST_IDLE;
                                end
                            end else begin
                                cnt_q <= w_cnt_m1;
                            end
                        end
                    end

                    // sdao_q tells the two ACK falls apart: the first fall
                    // (end of bit 8) pulls SDA low, the second (end of the
                    // ACK clock) releases it and moves on.
                    ST_DEV_ACK: begin
                        if (w_scl_fall) begin
                            if (sdao_q) begin
                                sdao_q <= 1'b0;
                            end else if (rw_q) begin
                                sr_q    <= w_cur;
                                sdao_q  <= w_cur[7];
                                cnt_q   <= 3'd7;
                                state_q <= ST_RD_DATA;
                            end else begin
                                sdao_q  <= 1'b1;
                                cnt_q   <= 3'd7;
                                state_q <= ST_REG_ADDR;
                            end
                        end
                    end

                    ST_REG_ADDR: begin
                        if (w_scl_rise) begin
                            sr_q <= w_byte;
                            if (w_last) begin
                                // Upper pointer bits beyond the register
                                // file size are ignored.
                                ptr_q   <= w_byte[AW-1:0];
                                state_q <= ST_REG_ACK;
                            end else begin
                                cnt_q <= w_cnt_m1;
                            end
                        end
                    end

                    ST_REG_ACK, ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (sdao_q) begin
                                sdao_q <= 1'b0;
                            end else begin
                                sdao_q  <= 1'b1;
                                cnt_q   <= 3'd7;
                                state_q <= ST_WR_DATA;
                            end
                        end
                    end

                    ST_WR_DATA: begin
                        if (w_scl_rise) begin
                            sr_q <= w_byte;
                            if (w_last) begin
                                // Commit only once the full byte is in; a
                                // START/STOP earlier leaves regs untouched.
                                regs_q[ptr_q] <= w_byte;
                                wr_strb_q     <= 1'b1;
                                wr_idx_q      <= ptr_q;
                                ptr_q         <= w_ptr_inc;
                                state_q       <= ST_WR_ACK;
                            end else begin
                                cnt_q <= w_cnt_m1;
                            end
                        end
                    end

                    // cnt_q holds the index of the bit currently on the bus.
                    ST_RD_DATA: begin
                        if (w_scl_fall) begin
                            if (w_last) begin
                                sdao_q  <= 1'b1;
                                mack_q  <= 1'b0;
                                state_q <= ST_RD_ACK;
                            end else begin
                                sdao_q <= sr_q[w_cnt_m1];
                                cnt_q  <= w_cnt_m1;
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            ptr_q <= w_ptr_inc;
                            if (sda_q[1]) begin
                                state_q <= ST_IDLE;
                            end else begin
                                mack_q <= 1'b1;
                            end
                        end else if (w_scl_fall && mack_q) begin
                            // ptr_q already advanced at the ACK rise.
                            sr_q    <= w_cur;
                            sdao_q  <= w_cur[7];
                            cnt_q   <= 3'd7;
                            mack_q  <= 1'b0;
                            state_q <= ST_RD_DATA;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        sdao_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sdao      = sdao_q;
    assign wr_strb   = wr_strb_q;
    assign wr_idx    = wr_idx_q;
    assign busy      = busy_q;
    assign lcl_rdata = regs_q[lcl_addr];

endmodule

`default_nettype wire
